memory_writer: RTL and testbench

Avalon-ST sink stage that captures one frame of 32-bit samples into the shared 8K-word on-chip sample memory, directly upstream of the DFT memory reader. After an arm request, it waits for a start of frame and writes FRAME_LENGTH consecutive beats to addresses 0 to FRAME_LENGTH-1. It then emits a one-cycle done pulse, which drives the reader's trigger input.

---
 rtl/memory_writer.sv | 150 +++++++++++++++
 tb/tb_memory_writer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_writer.sv
// memory_writer: Avalon-ST sink that captures one armed frame of 32-bit
// samples into the shared sample memory. It writes addresses
// 0..FRAME_LENGTH-1 and then pulses done to trigger the downstream reader.
//
// Optional build macro: MEMORY_WRITER_FRAME_CHECK_EN
//   defined     - sop/eop framing is enforced and errors are flagged (sticky)
//   not defined - sop/eop are ignored and the error output is held at 0
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for an arm request, sink not ready
// ARMED   | sink ready, discarding beats until one qualifies as a start
// CAPTURE | writing accepted beats to consecutive addresses
// DONE    | last word written this cycle, done pulses on the next one

module memory_writer #(
  parameter int FRAME_LENGTH = 1024,
  parameter int ADDR_WIDTH   = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memory_writer_arm,
  input  logic [31:0]           memory_writer_sink_data,
  input  logic                  memory_writer_sink_valid,
  input  logic                  memory_writer_sink_sop,
  input  logic                  memory_writer_sink_eop,
  output logic                  memory_writer_sink_ready,
  output logic [ADDR_WIDTH-1:0] memory_writer_writeaddress,
  output logic                  memory_writer_write,
  output logic [31:0]           memory_writer_writedata,
  output logic                  memory_writer_done,
  output logic [1:0]            memory_writer_status,
  output logic                  memory_writer_error
);

  localparam int CNT_W = $clog2(FRAME_LENGTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(FRAME_LENGTH - 1);

`ifdef MEMORY_WRITER_FRAME_CHECK_EN
  localparam bit FRAME_CHECK = 1'b1;
`else
  localparam bit FRAME_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             error_q;
  logic             accept;
  logic             sop_seen;
  logic             eop_seen;
  logic             start_ok;

  // Ready depends on state only so upstream sees no combinational path
  // from its own valid.
  assign memory_writer_sink_ready = (state == ARMED) || (state == CAPTURE);
  assign accept   = memory_writer_sink_valid && memory_writer_sink_ready;

  // Framing markers only count when the frame check is built in.
  assign sop_seen = FRAME_CHECK && memory_writer_sink_sop;
  assign eop_seen = FRAME_CHECK && memory_writer_sink_eop;
  assign start_ok = !FRAME_CHECK || memory_writer_sink_sop;

  assign memory_writer_status = state;
  assign memory_writer_error  = FRAME_CHECK ? error_q : 1'b0;

  // Capture sequencer with registered memory-port and done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                      <= IDLE;
      cnt                        <= '0;
      error_q                    <= 1'b0;
      memory_writer_write        <= 1'b0;
      memory_writer_writeaddress <= '0;
      memory_writer_writedata    <= '0;
      memory_writer_done         <= 1'b0;
    end else begin
      memory_writer_write <= 1'b0;
      memory_writer_done  <= 1'b0;
      if (accept) begin
        memory_writer_writedata <= memory_writer_sink_data;
      end

      unique case (state)
        IDLE: begin
          // The done cycle is already IDLE; an arm there belongs to the
          // previous capture and is not taken.
          if (memory_writer_arm && !memory_writer_done) begin
            state   <= ARMED;
            cnt     <= '0;
            error_q <= 1'b0;
          end
        end

        ARMED: begin
          if (accept && start_ok) begin
            memory_writer_write        <= 1'b1;
            memory_writer_writeaddress <= '0;
            cnt                        <= CNT_W'(1);
            state                      <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (accept) begin
            memory_writer_write <= 1'b1;
            if (sop_seen) begin
              // Unexpected start: restart the frame on this beat.
              error_q                    <= 1'b1;
              memory_writer_writeaddress <= '0;
              cnt                        <= CNT_W'(1);
            end else begin
              memory_writer_writeaddress <= ADDR_WIDTH'(cnt);
              if (cnt == LAST_ADDR) begin
                // A missing eop is flagged but the frame still completes.
                if (FRAME_CHECK && !memory_writer_sink_eop) begin
                  error_q <= 1'b1;
                end
                state <= DONE;
              end else if (eop_seen) begin
                // Short frame: keep the beat, flag it, wait for a new sop.
                error_q <= 1'b1;
                cnt     <= '0;
                state   <= ARMED;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end

        DONE: begin
          memory_writer_done <= 1'b1;
          state              <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_writer.sv
// tb_memory_writer: directed frame scenarios with random data and gaps.
// Expected writes are built per frame from the frame rules (address = beat
// position in the frame, one cycle after the accept) and compared with
// what a monitor records on the memory port.

module tb_memory_writer;

  localparam int FL = 1024;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          arm = 1'b0;
  logic [31:0]   data = '0;
  logic          valid = 1'b0;
  logic          sop = 1'b0;
  logic          eop = 1'b0;
  logic          ready;
  logic [AW-1:0] waddr;
  logic          write;
  logic [31:0]   wdata;
  logic          done;
  logic [1:0]    status;
  logic          error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          done_q[$];
  int          exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          exp_cyc_q[$];

  memory_writer #(.FRAME_LENGTH(FL), .ADDR_WIDTH(AW)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .memory_writer_arm          (arm),
    .memory_writer_sink_data    (data),
    .memory_writer_sink_valid   (valid),
    .memory_writer_sink_sop     (sop),
    .memory_writer_sink_eop     (eop),
    .memory_writer_sink_ready   (ready),
    .memory_writer_writeaddress (waddr),
    .memory_writer_write        (write),
    .memory_writer_writedata    (wdata),
    .memory_writer_done         (done),
    .memory_writer_status       (status),
    .memory_writer_error        (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (write === 1'b1) begin
        wr_addr_q.push_back(int'(waddr));
        wr_data_q.push_back(wdata);
        wr_cyc_q.push_back(cyc);
      end
      if (done === 1'b1) done_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arm from IDLE; returns at the drive point of the first ARMED cycle + 1.
  task automatic arm_it();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    @(negedge clk);
    chk("armed_status", status, 2'd1);
    chk("armed_ready", ready, 1'b1);
    chk("armed_error", error, 1'b0);
    tick();
  endtask

  // One beat after 'gap' idle cycles; expect_wr says whether it lands at exp_addr.
  task automatic send(input logic [31:0] d, input logic s, input logic e, input int gap,
                      input bit expect_wr, input int exp_addr, input bit rand_arm);
    for (int g = 0; g < gap; g++) begin
      valid = 1'b0;
      data  = $urandom;
      sop   = 1'($urandom_range(0, 1));
      eop   = 1'($urandom_range(0, 1));
      arm   = rand_arm ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    valid = 1'b1;
    data  = d;
    sop   = s;
    eop   = e;
    arm   = rand_arm ? 1'($urandom_range(0, 1)) : 1'b0;
    if (expect_wr) begin
      exp_addr_q.push_back(exp_addr);
      exp_data_q.push_back(d);
      exp_cyc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    chk("beat_ready", ready, 1'b1);
    tick();
    valid = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
    arm   = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    int n;
    chk({tag, "_wr_count"}, wr_addr_q.size(), exp_addr_q.size());
    n = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_wr_addr"}, wr_addr_q[i], exp_addr_q[i]);
      chk({tag, "_wr_data"}, wr_data_q[i], exp_data_q[i]);
      chk({tag, "_wr_latency"}, wr_cyc_q[i], exp_cyc_q[i]);
    end
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    exp_addr_q.delete(); exp_data_q.delete(); exp_cyc_q.delete();
  endtask

  // Called at the drive point of the cycle after the last accept.
  task automatic finish_frame(input string tag, input bit exp_err, input bit arm_at_done);
    int l1;
    l1 = cyc;
    @(negedge clk);
    chk({tag, "_last_status"}, status, 2'd3);
    chk({tag, "_last_write"}, write, 1'b1);
    chk({tag, "_last_done_low"}, done, 1'b0);
    tick();
    if (arm_at_done) arm = 1'b1;
    @(negedge clk);
    chk({tag, "_done_high"}, done, 1'b1);
    chk({tag, "_done_status"}, status, 2'd0);
    chk({tag, "_done_error"}, error, exp_err);
    tick();
    arm = 1'b0;
    @(negedge clk);
    chk({tag, "_after_done_low"}, done, 1'b0);
    chk({tag, "_after_status_idle"}, status, 2'd0);
    chk({tag, "_after_ready_low"}, ready, 1'b0);
    chk({tag, "_done_count"}, done_q.size(), 1);
    if (done_q.size() > 0) chk({tag, "_done_cycle"}, done_q[0], l1 + 1);
    done_q.delete();
    check_writes(tag);
    tick();
  endtask

  initial begin
    logic [31:0] d;
    logic        s;
    logic        e;

    // Reset values
    #2 rst = 1'b1;
    #1;
    chk("rst_write", write, 1'b0);
    chk("rst_addr", waddr, '0);
    chk("rst_data", wdata, '0);
    chk("rst_done", done, 1'b0);
    chk("rst_status", status, 2'd0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_error", error, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_status", status, 2'd0);
    chk("idle_ready", ready, 1'b0);
    tick();

    // Full-rate frame, data = index, arm during done must be ignored
    arm_it();
    for (int k = 0; k < FL; k++)
      send(32'(k), k == 0, k == FL - 1, 0, 1'b1, k, 1'b0);
    finish_frame("full", 1'b0, 1'b1);

    // Random gaps, random data, arm toggling during capture
    arm_it();
    for (int k = 0; k < FL; k++) begin
      d = $urandom;
`ifdef MEMORY_WRITER_FRAME_CHECK_EN
      s = (k == 0);
      e = (k == FL - 1);
`else
      s = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
`endif
      send(d, s, e, $urandom_range(0, 2), 1'b1, k, 1'b1);
    end
    finish_frame("gaps", 1'b0, 1'b0);

`ifdef MEMORY_WRITER_FRAME_CHECK_EN
    // Early eop on beat 500: error, back to ARMED, no done
    arm_it();
    for (int k = 0; k <= 500; k++)
      send($urandom, k == 0, k == 500, 0, 1'b1, k, 1'b0);
    @(negedge clk);
    chk("eop_status", status, 2'd1);
    chk("eop_error", error, 1'b1);
    chk("eop_write", write, 1'b1);
    tick();
    repeat (3) tick();
    chk("eop_no_done", done_q.size(), 0);
    check_writes("eop");

    // Good frame from ARMED keeps the sticky error
    for (int k = 0; k < FL; k++)
      send($urandom, k == 0, k == FL - 1, 0, 1'b1, k, 1'b0);
    finish_frame("after_eop", 1'b1, 1'b0);

    // New arm clears the error
    arm_it();

    // Pre-sop beats discarded; last beat lacks eop -> error but done fires
    for (int k = 0; k < 5; k++)
      send($urandom, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    for (int k = 0; k < FL; k++)
      send($urandom, k == 0, 1'b0, $urandom_range(0, 1), 1'b1, k, 1'b0);
    finish_frame("presop", 1'b1, 1'b0);
`else
    // No framing markers at all: capture starts on the first beat
    arm_it();
    for (int k = 0; k < FL; k++)
      send($urandom, 1'b0, 1'b0, 0, 1'b1, k, 1'b0);
    finish_frame("nochk", 1'b0, 1'b0);
`endif

    // Reset at beat 300 aborts immediately, pending write is dropped
    arm_it();
    for (int k = 0; k < 300; k++)
      send($urandom, k == 0, 1'b0, 0, 1'b1, k, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_write", write, 1'b0);
    chk("abort_addr", waddr, '0);
    chk("abort_data", wdata, '0);
    chk("abort_done", done, 1'b0);
    chk("abort_status", status, 2'd0);
    chk("abort_ready", ready, 1'b0);
    chk("abort_error", error, 1'b0);
    void'(exp_addr_q.pop_back());
    void'(exp_data_q.pop_back());
    void'(exp_cyc_q.pop_back());
    check_writes("abort");
    tick();
    tick();
    rst = 1'b0;
    tick();
    arm_it();
    for (int k = 0; k < FL; k++)
      send($urandom, k == 0, k == FL - 1, 0, 1'b1, k, 1'b0);
    finish_frame("post_rst", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
